// File: rtl/clause_db_pkg.sv
// Shared types and constants for the clause database arbiter.
//   state_t          : arbiter FSM state (IDLE, ACCESS)
//   DEF_DATA_SIZE    : default clause word width
//   DEF_ADDRESS_SIZE : default database address width
//   id_w()           : requester-id width for a given requester count
package clause_db_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int DEF_DATA_SIZE    = 8;
  localparam int DEF_ADDRESS_SIZE = 8;

  // A single requester still needs a 1-bit id so the vectors stay legal.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clause_db_arbiter_rr_picker.sv
// Round-robin picker (combinational).
//   elig  : eligible requester vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot winner (zero when nothing is eligible)
//   id    : binary winner index (zero when nothing is eligible)
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] elig,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    id
);

  logic [NUM_REQ-1:0] rot;
  logic               found;
  int                 sel;

  always_comb begin
    // Rotate so that bit k of rot is requester (ptr+k) mod NUM_REQ.
    rot   = NUM_REQ'({elig, elig} >> ptr);
    found = 1'b0;
    sel   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sel   = int'(ptr) + k;
      end
    end
    if (sel >= NUM_REQ) sel = sel - NUM_REQ;
    id    = found ? ID_W'(sel) : '0;
    grant = found ? (NUM_REQ'(1) << id) : '0;
  end

endmodule

// File: rtl/clause_db_arbiter.sv
// Round-robin arbiter sharing the single-port clause database between
// NUM_REQ requesters, sequencing its active-low mem_request / mem_work
// handshake.
//   clock, reset          : clock, synchronous active-low reset
//   req, we               : per-requester level request and write(1)/read(0)
//   req_addr, req_wdata   : packed per-requester address / write data
//   ack, err, rdata       : one-hot completion pulse, timeout flag, read data
//   busy                  : high while an access is outstanding
//   mem_request, data_read, data_write, address, d_in : database command
//   d_out, mem_work       : database read data and ready/op-complete
module clause_db_arbiter
  import clause_db_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int DATA_SIZE    = DEF_DATA_SIZE,
  parameter int ADDRESS_SIZE = DEF_ADDRESS_SIZE,
  parameter int TIMEOUT      = 8
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              we,
  input  logic [NUM_REQ*ADDRESS_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*DATA_SIZE-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]              ack,
  output logic                            err,
  output logic [DATA_SIZE-1:0]            rdata,
  output logic                            busy,
  output logic                            mem_request,
  output logic                            data_read,
  output logic                            data_write,
  output logic [ADDRESS_SIZE-1:0]         address,
  output logic [DATA_SIZE-1:0]            d_in,
  input  logic [DATA_SIZE-1:0]            d_out,
  input  logic                            mem_work
);

  localparam int ID_W  = id_w(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT);

  state_t             state;
  logic [ID_W-1:0]    ptr, win, gid;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] elig, grant;
  logic               done, tmo;

  logic [NUM_REQ-1:0][ADDRESS_SIZE-1:0] addr_v;
  logic [NUM_REQ-1:0][DATA_SIZE-1:0]    data_v;

  assign addr_v = req_addr;
  assign data_v = req_wdata;

  // A requester being acked this cycle is still holding its old request
  // level; masking it stops the same command from being issued twice.
  assign elig = req & ~ack;

  rr_picker #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_pick (
    .elig (elig),
    .ptr  (ptr),
    .grant(grant),
    .id   (gid)
  );

  assign done = !mem_work;
  assign tmo  = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= IDLE;
      ptr         <= '0;
      win         <= '0;
      cnt         <= '0;
      ack         <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      busy        <= 1'b0;
      mem_request <= 1'b1;
      data_read   <= 1'b0;
      data_write  <= 1'b0;
      address     <= '0;
      d_in        <= '0;
    end else begin
      ack <= '0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          // mem_work must be a clean 1; X or 0 after reset never issues.
          if (mem_work == 1'b1 && |grant) begin
            win         <= gid;
            address     <= addr_v[gid];
            d_in        <= data_v[gid];
            mem_request <= 1'b0;
            data_write  <= we[gid];
            data_read   <= !we[gid];
            busy        <= 1'b1;
            cnt         <= '0;
            state       <= ACCESS;
          end
        end
        ACCESS: begin
          if (done || tmo) begin
            // Completion and timeout share the release; only a completed
            // read updates rdata, and err marks the abort.
            if (done && data_read) rdata <= d_out;
            err         <= !done;
            ack         <= NUM_REQ'(1) << win;
            ptr         <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
            mem_request <= 1'b1;
            data_read   <= 1'b0;
            data_write  <= 1'b0;
            busy        <= 1'b0;
            state       <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_db_arbiter.sv
// Directed self-checking bench for clause_db_arbiter with a behavioural
// single-port database model.
module tb_clause_db_arbiter;
  import clause_db_pkg::*;

  localparam int NR = 2;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic [NR-1:0]    req, we, ack;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic             err, busy, mem_request, data_read, data_write, mem_work;
  logic [DW-1:0]    rdata, d_in, d_out;
  logic [AW-1:0]    address;

  // database model controls
  logic          db_en, db_stuck, pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  logic [DW-1:0] mem [256];

  int tests = 0;
  int fails = 0;

  logic [1:0] t3_exp [12] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10,
                              2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10};

  clause_db_arbiter #(
    .NUM_REQ(NR), .DATA_SIZE(DW), .ADDRESS_SIZE(AW), .TIMEOUT(TO)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .ack        (ack),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .mem_request(mem_request),
    .data_read  (data_read),
    .data_write (data_write),
    .address    (address),
    .d_in       (d_in),
    .d_out      (d_out),
    .mem_work   (mem_work)
  );

  always #5 clock = ~clock;

  // Executes on an edge seeing mem_request=0 and mem_work=1, then holds
  // mem_work=0 with d_out valid for one cycle. db_stuck models a hung database.
  always @(posedge clock) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    if (!db_en) begin
      mem_work <= 1'b0;
      d_out    <= '0;
    end else if (!mem_request && mem_work && !db_stuck) begin
      mem_work <= 1'b0;
      if (data_write) mem[address] <= d_in;
      if (data_read)  d_out <= mem[address];
    end else begin
      mem_work <= 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    reset = 1'b0; req = '0; we = '0; req_addr = '0; req_wdata = '0;
    db_en = 1'b0; db_stuck = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    cyc(1);
    db_en = 1'b1; pl_en = 1'b1; pl_addr = 8'h05; pl_data = 8'hA3;
    cyc(1);
    pl_en = 1'b0;
    cyc(1);

    // reset state
    chk("rst_ack",   32'(ack),         32'h0);
    chk("rst_err",   32'(err),         32'h0);
    chk("rst_rdata", 32'(rdata),       32'h0);
    chk("rst_busy",  32'(busy),        32'h0);
    chk("rst_mreq",  32'(mem_request), 32'h1);
    chk("rst_cmd",   32'({data_read, data_write}), 32'h0);
    chk("rst_addr",  32'(address),     32'h0);
    chk("rst_din",   32'(d_in),        32'h0);
    chk("rst_state", 32'(dut.state),   32'(IDLE));
    reset = 1'b1;

    // single read, requester 0, addr 05 -> A3
    req = 2'b01; we = 2'b00; req_addr[7:0] = 8'h05;
    cyc(1);
    chk("t1_mreq_e0", 32'(mem_request), 32'h0);
    chk("t1_rd",      32'(data_read),   32'h1);
    chk("t1_addr",    32'(address),     32'h05);
    chk("t1_busy",    32'(busy),        32'h1);
    cyc(1);
    chk("t1_mreq_e1", 32'(mem_request), 32'h0);
    chk("t1_noack",   32'(ack),         32'h0);
    cyc(1);
    chk("t1_ack",     32'(ack),         32'h1);
    chk("t1_err",     32'(err),         32'h0);
    chk("t1_rdata",   32'(rdata),       32'hA3);
    chk("t1_mreq_e2", 32'(mem_request), 32'h1);
    chk("t1_busy0",   32'(busy),        32'h0);
    req = 2'b00;
    cyc(1);

    // write 3C to 02 from requester 1, then read it back
    req = 2'b10; we = 2'b10; req_addr[15:8] = 8'h02; req_wdata[15:8] = 8'h3C;
    cyc(1);
    chk("t2_wr",    32'(data_write), 32'h1);
    chk("t2_din",   32'(d_in),       32'h3C);
    chk("t2_addr",  32'(address),    32'h02);
    cyc(2);
    chk("t2_wack",  32'(ack),        32'h2);
    chk("t2_wrd",   32'(rdata),      32'hA3);
    chk("t2_werr",  32'(err),        32'h0);
    we = 2'b00;
    cyc(1);
    chk("t2_hold",  32'(mem_request), 32'h1);
    cyc(1);
    chk("t2_rissue", 32'({mem_request, data_read}), 32'h1);
    cyc(2);
    chk("t2_rack",  32'(ack),        32'h2);
    chk("t2_rdata", 32'(rdata),      32'h3C);
    req = 2'b00;
    cyc(1);

    // both requesters continuous: grants alternate every 3 cycles
    req = 2'b11; we = 2'b00;
    for (int k = 0; k < 12; k++) begin
      cyc(1);
      chk($sformatf("t3_ack%0d", k), 32'(ack), 32'(t3_exp[k]));
      if (t3_exp[k] != 2'b00)
        chk($sformatf("t3_rdata%0d", k), 32'(rdata),
            (t3_exp[k] == 2'b01) ? 32'hA3 : 32'h3C);
    end
    req = 2'b00;
    cyc(1);

    // hung database: timeout after TO cycles in ACCESS
    db_stuck = 1'b1;
    req = 2'b01;
    cyc(8);
    chk("t4_pre_ack",  32'(ack),         32'h0);
    chk("t4_pre_mreq", 32'(mem_request), 32'h0);
    cyc(1);
    chk("t4_ack",   32'(ack),         32'h1);
    chk("t4_err",   32'(err),         32'h1);
    chk("t4_mreq",  32'(mem_request), 32'h1);
    chk("t4_busy",  32'(busy),        32'h0);
    chk("t4_rdata", 32'(rdata),       32'h3C);
    chk("t4_ptr",   32'(dut.ptr),     32'h1);
    req = 2'b10; req_addr[15:8] = 8'h05; db_stuck = 1'b0;
    cyc(1);
    chk("t4_next_issue", 32'(mem_request), 32'h0);
    cyc(2);
    chk("t4_next_ack",   32'(ack),   32'h2);
    chk("t4_next_err",   32'(err),   32'h0);
    chk("t4_next_rdata", 32'(rdata), 32'hA3);
    req = 2'b00;
    cyc(1);

    // reset on the cycle after issue abandons the access
    req = 2'b01; req_addr[7:0] = 8'h02;
    cyc(1);
    chk("t5_issue", 32'(mem_request), 32'h0);
    reset = 1'b0;
    cyc(1);
    chk("t5_mreq",  32'(mem_request), 32'h1);
    chk("t5_ack",   32'(ack),         32'h0);
    chk("t5_state", 32'(dut.state),   32'(IDLE));
    chk("t5_busy",  32'(busy),        32'h0);
    reset = 1'b1;
    cyc(1);
    chk("t5_wait",  32'(mem_request), 32'h1);
    for (int n = 0; n < 10 && ack == 2'b00; n++) cyc(1);
    chk("t5_ack_after", 32'(ack),   32'h1);
    chk("t5_rdata",     32'(rdata), 32'h3C);
    chk("t5_err",       32'(err),   32'h0);
    req = 2'b00;
    cyc(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clause_db_arbiter.md
Name: clause_db_arbiter

Overview:
- Shares the single-port clause database between NUM_REQ requesters, e.g. the clause loader and the BCP engine.
- Arbitration is round-robin.
- Sequences the database's active-low mem_request / mem_work handshake.
- Returns read data with a one-cycle ack per requester and flags stalled accesses with a timeout error.

Parameters:
NUM_REQ, 2, number of requesters
DATA_SIZE, 8, clause word width
ADDRESS_SIZE, 8, database address width
TIMEOUT, 8, max cycles in ACCESS before abort (>=2)

Ports:
clock  in  1  system clock
reset  in  1  synchronous active-low reset
req  in  NUM_REQ  per-requester access request (level)
we  in  NUM_REQ  per-requester write(1)/read(0)
req_addr  in  NUM_REQ*ADDRESS_SIZE  packed addresses, requester i at slice i
req_wdata  in  NUM_REQ*DATA_SIZE  packed write data
ack  out  NUM_REQ  one-cycle completion pulse, one-hot
err  out  1  high with ack when the access timed out
rdata  out  DATA_SIZE  read data, valid while ack is high
busy  out  1  high in ACCESS
mem_request  out  1  database strobe, active-low
data_read  out  1  database read command
data_write  out  1  database write command
address  out  ADDRESS_SIZE  database address
d_in  out  DATA_SIZE  database write data
d_out  in  DATA_SIZE  database read data
mem_work  in  1  database ready (1) / op-complete (0)

Behaviour:
- One clock. Reset is synchronous, active-low, and all outputs are registered.
- Reset values:
  - ack=0, err=0, rdata=0, busy=0
  - mem_request=1, data_read=0, data_write=0, address=0, d_in=0
  - state=IDLE, rr pointer=0, timeout counter=0
- Reset mid-access: the access is abandoned with no ack, and mem_request returns to 1 on that edge.
- Database contract: the database executes on the edge where it samples mem_request=0 and mem_work=1. mem_work is then 0 for one cycle, and d_out holds the read data during that cycle. mem_work then returns to 1.
- IDLE:
  - Issues only when mem_work==1 and at least one eligible req is high. Otherwise it waits; mem_work=X/0 after reset never issues.
  - Eligible means req[i]=1 and ack[i]=0 this cycle. A just-acked requester may present its next command at the ack edge; that command is served from the following IDLE cycle.
  - Winner: first eligible index at or after the rr pointer, wrapping modulo NUM_REQ.
  - On the issue edge: latch the winner id; drive address and d_in from its slices; mem_request=0; data_write=we[i]; data_read=!we[i]; busy=1; clear the counter; go to ACCESS.
- ACCESS:
  - Hold mem_request=0 and the command stable.
  - If mem_work is sampled 0: mem_request=1, data_read=0, data_write=0; rdata=d_out on reads (unchanged on writes); ack[winner]=1, err=0; rr pointer=winner+1 mod NUM_REQ; busy=0; go to IDLE.
  - Otherwise, if counter==TIMEOUT-1: the same release, but ack[winner]=1, err=1, rdata unchanged; pointer advances. Otherwise counter+1.
- Timing: with a ready database, the issue edge is E0, the database executes at E1, and the arbiter samples mem_work=0 at E2 and acks. The next issue is no earlier than E3, giving 3 cycles per access.
- Requesters hold req, we, addr and wdata stable from assertion until ack. The arbiter ignores changes to a non-winner's inputs.
- A write never drives rdata.
- ack is never high for more than one requester, and never for two consecutive cycles for the same access.

Decomposition:
- Package clause_db_pkg: the state enum (IDLE, ACCESS), default DATA_SIZE/ADDRESS_SIZE constants, and the clog2-based requester-id width.
- One sub-module: rr_picker, combinational. Inputs are the eligible vector and the pointer; outputs are a one-hot grant and a binary id.

Test Plan:
- Single read, requester 0, addr 8'h05 holding 8'hA3: ack[0] pulses 2 cycles after issue; rdata=8'hA3, err=0, mem_request low exactly 2 cycles.
- Write then read, requester 1, addr 8'h02: write 8'h3C, then read 8'h02 -> rdata=8'h3C. rdata does not change during the write's ack.
- Both requesters hold req continuously, pointer=0 -> grants alternate 0,1,0,1. Accesses are spaced 3 cycles apart and ack stays one-hot.
- Database model holds mem_work=1 for ever -> after TIMEOUT=8 cycles in ACCESS: ack with err=1, mem_request=1, pointer advanced; the next requester is then served normally.
- reset driven low on the cycle after issue -> next edge mem_request=1, state IDLE, no ack. After release, a new read completes correctly.
